reduce_scheduler: RTL and testbench
===================================

Name: reduce_scheduler

Overview:
- Arbitrates N router input ports onto the single packet input of the reduction unit, one packet per cycle.
- Per-slot hazard timers ensure that no reduction packet reaches a reduction table slot while that slot's adder result is still in flight.
- Non-reduction packets bypass the hazard check.
- Sits between the port input FIFOs and reduce_unit, and drives its packetA input.

Parameters:
- NumPorts, 4, number of requesting ports.
- lg_numports, 2, log2 of NumPorts.
- rank_z / rank_y / rank_x, 3'b0 each, this node's coordinates; used for slot index.
- PktWidth, 85, packet width: 82-bit flit plus 3-bit children field.
- SlotBits, 1, log2 of reduction table size.
- AdderLatency, 14, adder pipeline depth in cycles.
- TimerWidth, 5, hazard timer width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NumPorts  per-port request; that port's FIFO is non-empty.
- pkt_in  input  NumPorts*PktWidth  port p packet at [p*PktWidth +: PktWidth].
- sink_ready  input  1  reduction unit can accept a packet this cycle.
- grant  output  NumPorts  one-hot, combinational; the port pops its FIFO in this cycle.
- pkt_out  output  PktWidth  registered packet to the reduction unit.
- pkt_valid  output  1  registered; pkt_out holds a packet.
- slot_busy  output  2**SlotBits  per-slot timer nonzero.

Behaviour:
- Field positions:
  - Valid bit = 81.
  - dst = [80:72], with dst_z = [80:78].
  - tag = [45:38].
  - op = [35:32].
- Reduction packet: op[3:2] == 2'b11 and valid bit set.
- Slot index of a packet:
  - If dst == {rank_z, rank_y, rank_x}: tag[SlotBits-1:0].
  - Otherwise: dst_z[SlotBits-1:0].
- Eligibility: port p is eligible when req[p]=1 and either pkt_in[p] is a non-reduction packet, or slot_timer[slot(p)] == 0.
- Arbitration is round-robin:
  - Search starts at rr_ptr; the first eligible port is granted.
  - After a grant to p, rr_ptr <= (p+1) mod NumPorts.
  - With no grant, rr_ptr holds.
- grant is all-zero when sink_ready=0, when rst=1, or when no port is eligible.
- Output register, latency 1:
  - On a grant, next cycle pkt_out = pkt_in[p] and pkt_valid = 1.
  - With no grant, next cycle pkt_out = 0 (valid bit 0) and pkt_valid = 0.
- Hazard timers, one per slot:
  - On grant of a reduction packet to slot s: slot_timer[s] <= AdderLatency+1 (15).
  - Every other nonzero timer decrements by 1 each cycle.
  - A timer is loaded only when it is 0, so load and decrement never collide on the same slot.
- Two eligible ports targeting the same free slot in the same cycle: only one is granted, that slot's timer loads, and the other port is ineligible until the timer returns to 0.
- A port blocked by a busy slot does not block other ports (no head-of-line block across ports).
- sink_ready=0: timers continue to decrement and rr_ptr holds.
- Reset (including mid-operation): on the next edge, pkt_out=0, pkt_valid=0, all timers 0, rr_ptr=0, slot_busy=0. Any in-flight hazard state is discarded.
- Widths: timer arithmetic is unsigned, with no wrap below 0.

Optional Feature:
- Macro: REDUCE_SCHED_STALL_CNT_EN.
- When defined:
  - Adds output stall_count, 16 bits.
  - Increments (saturating at 16'hFFFF) each cycle in which at least one req is masked solely by a busy slot while sink_ready=1.
  - Cleared by rst.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Single port 0, non-reduction packet (op=4'b0111), sink_ready=1 -> grant=0001 in the same cycle; pkt_valid=1 with pkt_out equal to the input packet one cycle later; slot_busy stays 0.
- Ports 0 and 2 each send reduction packets (op=4'b1111) to slots 0 and 1 respectively, every cycle -> alternating grants 0001, 0100; each slot is re-granted only after 15 cycles, with slot_busy high for 15 cycles.
- All 4 ports request non-reduction packets continuously -> grants 0001, 0010, 0100, 1000, 0001 in rotation.
- Port 1 targets busy slot 0 (timer=7) while port 3 targets free slot 1 -> port 3 is granted; port 1 is granted exactly 7 cycles later; stall_count increments by 7 when REDUCE_SCHED_STALL_CNT_EN is defined.
- sink_ready=0 for 5 cycles with requests pending -> grant=0 and pkt_valid=0; a timer loaded to 15 reads 10 afterwards; rr_ptr is unchanged.
- rst asserted while timer=9 and pkt_valid=1 -> next cycle all outputs are 0 and timers are 0; a request to the same slot is granted on the first cycle after rst deasserts.

Source files
------------

// File: rtl/reduce_scheduler_if.sv
// -----------------------------------------------------------------------------
// reduce_scheduler_if
//   Bundles the port-side request/packet bus, the reduction-unit sink
//   handshake and the scheduler's status outputs.
//
//   Handshake: a packet leaves port p in the cycle where req[p] and grant[p]
//   are both high; the port pops its FIFO in that same cycle. grant is only
//   raised while sink_ready is high, and the granted packet appears on
//   pkt_out with pkt_valid one cycle later.
//
//   Signals
//     req        [NumPorts]           port FIFO non-empty
//     pkt_in     [NumPorts*PktWidth]  port p packet at [p*PktWidth +: PktWidth]
//     sink_ready                      reduction unit can accept a packet
//     grant      [NumPorts]           one-hot pop strobe (combinational)
//     pkt_out    [PktWidth]           registered packet to the reduction unit
//     pkt_valid                       registered, pkt_out holds a packet
//     slot_busy  [2**SlotBits]        per-slot hazard timer nonzero
//
//   Modports: master = port/sink side, slave = scheduler.
// -----------------------------------------------------------------------------
interface reduce_scheduler_if #(
    parameter int NumPorts = 4,
    parameter int PktWidth = 85,
    parameter int SlotBits = 1
);
    logic [NumPorts-1:0]          req;
    logic [NumPorts*PktWidth-1:0] pkt_in;
    logic                         sink_ready;
    logic [NumPorts-1:0]          grant;
    logic [PktWidth-1:0]          pkt_out;
    logic                         pkt_valid;
    logic [(2**SlotBits)-1:0]     slot_busy;

    modport master (
        output req, pkt_in, sink_ready,
        input  grant, pkt_out, pkt_valid, slot_busy
    );

    modport slave (
        input  req, pkt_in, sink_ready,
        output grant, pkt_out, pkt_valid, slot_busy
    );
endinterface

// File: rtl/reduce_scheduler.sv
// -----------------------------------------------------------------------------
// reduce_scheduler
//   Round-robin arbiter that moves one packet per cycle from NumPorts router
//   input FIFOs onto the reduction unit's packetA input. Reduction packets
//   are held back while the reduction-table slot they target still has an
//   adder result in flight (per-slot hazard timer nonzero); non-reduction
//   packets bypass the hazard check. A blocked port never blocks others.
//
//   Ports
//     clk          clock
//     rst          synchronous, active-high reset
//     bus          reduce_scheduler_if.slave (req, pkt_in, sink_ready in;
//                  grant, pkt_out, pkt_valid, slot_busy out)
//     stall_count  16-bit saturating count of cycles in which some request
//                  was masked only by a busy slot while sink_ready was high
//                  (present only when REDUCE_SCHED_STALL_CNT_EN is defined)
//
//   Optional feature macro: REDUCE_SCHED_STALL_CNT_EN
// -----------------------------------------------------------------------------
module reduce_scheduler #(
    parameter int         NumPorts     = 4,
    parameter int         lg_numports  = 2,
    parameter logic [2:0] rank_z       = 3'b0,
    parameter logic [2:0] rank_y       = 3'b0,
    parameter logic [2:0] rank_x       = 3'b0,
    parameter int         PktWidth     = 85,
    parameter int         SlotBits     = 1,
    parameter int         AdderLatency = 14,
    parameter int         TimerWidth   = 5
) (
    input  logic               clk,
    input  logic               rst,
    reduce_scheduler_if.slave  bus
`ifdef REDUCE_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]        stall_count
`endif
);

    localparam int                    NumSlots  = 2**SlotBits;
    localparam logic [8:0]            LocalDst  = {rank_z, rank_y, rank_x};
    // One extra cycle so the slot is reopened only after the adder result
    // has been written back.
    localparam logic [TimerWidth-1:0] TimerLoad = TimerWidth'(AdderLatency + 1);

    logic [TimerWidth-1:0]  r_timer [NumSlots];
    logic [lg_numports-1:0] r_rr_ptr;
    logic [PktWidth-1:0]    r_pkt_out;
    logic                   r_pkt_valid;

    logic [NumPorts-1:0]    w_is_red;
    logic [NumPorts-1:0]    w_eligible;
    logic [NumPorts-1:0]    w_masked;
    logic [SlotBits-1:0]    w_slot [NumPorts];
    logic                   w_found;
    logic [lg_numports-1:0] w_sel;
    logic [NumPorts-1:0]    w_grant;
    logic [PktWidth-1:0]    w_sel_pkt;

    // Per-port classification: reduction or not, target slot, eligibility.
    always_comb begin
        logic                w_p_red;
        logic [SlotBits-1:0] w_p_slot;
        w_is_red   = '0;
        w_eligible = '0;
        w_masked   = '0;
        w_p_red    = 1'b0;
        w_p_slot   = '0;
        for (int p = 0; p < NumPorts; p++) begin
            w_p_red = bus.pkt_in[p*PktWidth + 81] &&
                      (bus.pkt_in[p*PktWidth + 34 +: 2] == 2'b11);
            // Local destination: slot comes from the tag; otherwise the
            // packet is addressed by its destination z coordinate.
            if (bus.pkt_in[p*PktWidth + 72 +: 9] == LocalDst) begin
                w_p_slot = bus.pkt_in[p*PktWidth + 38 +: SlotBits];
            end else begin
                w_p_slot = bus.pkt_in[p*PktWidth + 78 +: SlotBits];
            end
            w_is_red[p]   = w_p_red;
            w_slot[p]     = w_p_slot;
            w_eligible[p] = bus.req[p] && (!w_p_red || (r_timer[w_p_slot] == '0));
            w_masked[p]   = bus.req[p] && w_p_red && (r_timer[w_p_slot] != '0);
        end
    end

    // Round-robin search starting at r_rr_ptr. The index wraps naturally in
    // lg_numports bits, so NumPorts must equal 2**lg_numports.
    always_comb begin
        logic [lg_numports-1:0] w_idx;
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        if (bus.sink_ready && !rst) begin
            for (int i = 0; i < NumPorts; i++) begin
                w_idx = r_rr_ptr + lg_numports'(i);
                if (!w_found && w_eligible[w_idx]) begin
                    w_found = 1'b1;
                    w_sel   = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_grant   = '0;
        w_sel_pkt = bus.pkt_in[int'(w_sel)*PktWidth +: PktWidth];
        if (w_found) begin
            w_grant[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_pkt_out   <= '0;
            r_pkt_valid <= 1'b0;
            for (int s = 0; s < NumSlots; s++) begin
                r_timer[s] <= '0;
            end
        end else begin
            r_pkt_valid <= w_found;
            r_pkt_out   <= w_found ? w_sel_pkt : '0;
            if (w_found) begin
                r_rr_ptr <= w_sel + 1'b1;
            end
            // A granted reduction packet always sees its slot timer at zero,
            // so loading and decrementing never target the same slot.
            for (int s = 0; s < NumSlots; s++) begin
                if (w_found && w_is_red[w_sel] && (w_slot[w_sel] == SlotBits'(s))) begin
                    r_timer[s] <= TimerLoad;
                end else if (r_timer[s] != '0) begin
                    r_timer[s] <= r_timer[s] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.slot_busy = '0;
        for (int s = 0; s < NumSlots; s++) begin
            bus.slot_busy[s] = (r_timer[s] != '0);
        end
    end

    assign bus.grant     = w_grant;
    assign bus.pkt_out   = r_pkt_out;
    assign bus.pkt_valid = r_pkt_valid;

`ifdef REDUCE_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (bus.sink_ready && (|w_masked) && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_reduce_scheduler.sv
module tb_reduce_scheduler;

  localparam int NP = 4;
  localparam int PW = 85;

  typedef struct {
    logic [NP-1:0]    req;
    logic [NP*PW-1:0] pkts;
    logic             sr;
    logic [NP-1:0]    exp_grant;
    logic [1:0]       exp_busy;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  logic [PW-1:0]    exp_q[$];
  logic [NP*PW-1:0] drv_pkts;

  logic [PW-1:0] zp, nr0, nr1, nr2, nr3, inv2, red0, red1, remote1;
  vec_t          vecs[10];

  reduce_scheduler_if #(.NumPorts(NP), .PktWidth(PW), .SlotBits(1)) bus();

`ifdef REDUCE_SCHED_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  reduce_scheduler dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef REDUCE_SCHED_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic logic [PW-1:0] mk_pkt(input logic v, input logic [8:0] dst,
                                           input logic [7:0] tag, input logic [3:0] op,
                                           input logic [2:0] ch);
    logic [PW-1:0] p;
    p = '0;
    p[84:82] = ch;
    p[81]    = v;
    p[80:72] = dst;
    p[45:38] = tag;
    p[35:32] = op;
    p[31:0]  = {24'hC0FFEE, tag};
    return p;
  endfunction

  function automatic vec_t mkv(input logic [NP-1:0] r, input logic [NP*PW-1:0] pk,
                               input logic sr, input logic [NP-1:0] eg, input logic [1:0] eb);
    vec_t v;
    v.req = r;
    v.pkts = pk;
    v.sr = sr;
    v.exp_grant = eg;
    v.exp_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [NP-1:0] r, input logic [NP*PW-1:0] pk, input logic sr);
    bus.req        = r;
    bus.pkt_in     = pk;
    bus.sink_ready = sr;
    drv_pkts       = pk;
  endtask

  // Called at posedge+1 with inputs applied: checks the combinational grant
  // and slot_busy mid-cycle, then the registered output after the next edge.
  task automatic step(input string nm, input logic [NP-1:0] eg, input logic [1:0] eb);
    logic [PW-1:0] e;
    #2;
    chk({nm, "_grant"}, PW'(bus.grant), PW'(eg));
    chk({nm, "_busy"}, PW'(bus.slot_busy), PW'(eb));
    e = '0;
    for (int p = 0; p < NP; p++) if (eg[p]) e = drv_pkts[p*PW +: PW];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({nm, "_pkt_out"}, bus.pkt_out, e);
    chk({nm, "_pkt_valid"}, PW'(bus.pkt_valid), PW'(eg != '0));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [NP-1:0] eg;
    logic [1:0]    eb;
    n_checks = 0;
    n_pass   = 0;

    zp      = '0;
    nr0     = mk_pkt(1'b1, 9'h000, 8'h10, 4'b0111, 3'd1);
    nr1     = mk_pkt(1'b1, 9'h000, 8'h11, 4'b0111, 3'd2);
    nr2     = mk_pkt(1'b1, 9'h000, 8'h12, 4'b0111, 3'd3);
    nr3     = mk_pkt(1'b1, 9'h000, 8'h13, 4'b0111, 3'd4);
    inv2    = mk_pkt(1'b0, 9'h000, 8'h00, 4'b1111, 3'd5);
    red0    = mk_pkt(1'b1, 9'h000, 8'h00, 4'b1111, 3'd6);
    red1    = mk_pkt(1'b1, 9'h000, 8'h01, 4'b1111, 3'd7);
    remote1 = mk_pkt(1'b1, {3'd1, 3'd2, 3'd3}, 8'h00, 4'b1111, 3'd2);

    // rr_ptr trace: 0 -> 1 -> 0 -> 1 -> 2 -> 3 -> 0 -> 1 -> 3 -> 3 -> 3
    vecs[0] = mkv(4'b0001, {zp, zp, zp, nr0},    1'b1, 4'b0001, 2'b00);
    vecs[1] = mkv(4'b1000, {nr3, zp, zp, zp},    1'b1, 4'b1000, 2'b00);
    vecs[2] = mkv(4'b1111, {nr3, nr2, nr1, nr0}, 1'b1, 4'b0001, 2'b00);
    vecs[3] = mkv(4'b1111, {nr3, nr2, nr1, nr0}, 1'b1, 4'b0010, 2'b00);
    vecs[4] = mkv(4'b1111, {nr3, nr2, nr1, nr0}, 1'b1, 4'b0100, 2'b00);
    vecs[5] = mkv(4'b1111, {nr3, nr2, nr1, nr0}, 1'b1, 4'b1000, 2'b00);
    vecs[6] = mkv(4'b1111, {nr3, nr2, nr1, nr0}, 1'b1, 4'b0001, 2'b00);
    vecs[7] = mkv(4'b0100, {zp, inv2, zp, zp},   1'b1, 4'b0100, 2'b00);
    vecs[8] = mkv(4'b0100, {zp, inv2, zp, zp},   1'b1, 4'b0100, 2'b00);
    vecs[9] = mkv(4'b0000, {zp, zp, zp, zp},     1'b1, 4'b0000, 2'b00);

    // Reset with a pending request: grant must stay low.
    rst = 1'b1;
    drive(4'b0001, {zp, zp, zp, nr0}, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", PW'(bus.grant), PW'(4'b0000));
    chk("rst_pkt_valid", PW'(bus.pkt_valid), PW'(1'b0));
    chk("rst_pkt_out", bus.pkt_out, zp);
    chk("rst_busy", PW'(bus.slot_busy), PW'(2'b00));
`ifdef REDUCE_SCHED_STALL_CNT_EN
    chk("rst_stall", PW'(stall_count), PW'(16'd0));
`endif
    rst = 1'b0;

    // Table: single port, rotation, invalid-bit bypass.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].req, vecs[i].pkts, vecs[i].sr);
      step($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_busy);
    end

    // Port 1 blocked on slot 0; port 3 targets free slot 1 when timer0 = 7.
    begin
`ifdef REDUCE_SCHED_STALL_CNT_EN
      logic [15:0] s9;
      s9 = '0;
`endif
      for (int k = 0; k <= 16; k++) begin
`ifdef REDUCE_SCHED_STALL_CNT_EN
        if (k == 9) s9 = stall_count;
        if (k == 16) chk("c_stall_delta", PW'(stall_count - s9), PW'(16'd7));
`endif
        if (k == 9) drive(4'b1010, {red1, zp, red0, zp}, 1'b1);
        else        drive(4'b0010, {zp, zp, red0, zp}, 1'b1);
        eg = (k == 0 || k == 16) ? 4'b0010 : ((k == 9) ? 4'b1000 : 4'b0000);
        eb = (k == 0) ? 2'b00 : ((k <= 9) ? 2'b01 : ((k <= 15) ? 2'b11 : 2'b10));
        step($sformatf("c%0d", k), eg, eb);
      end
    end

    // Keep pkt_valid high, then reset while timer0 = 9 and timer1 = 2.
    for (int k = 0; k < 6; k++) begin
      drive(4'b0001, {zp, zp, zp, nr0}, 1'b1);
      step($sformatf("e%0d", k), 4'b0001, 2'b11);
    end
    rst = 1'b1;
    drive(4'b0001, {zp, zp, zp, nr0}, 1'b1);
    step("e_rst", 4'b0000, 2'b11);
    rst = 1'b0;
`ifdef REDUCE_SCHED_STALL_CNT_EN
    chk("e_stall_cleared", PW'(stall_count), PW'(16'd0));
`endif
    drive(4'b0010, {zp, zp, red0, zp}, 1'b1);
    step("e_first", 4'b0010, 2'b00);

    // sink_ready low for 5 cycles: timer0 15 -> 10, rr_ptr holds at 2.
    for (int k = 1; k <= 16; k++) begin
`ifdef REDUCE_SCHED_STALL_CNT_EN
      if (k == 6)  chk("d_stall_hold", PW'(stall_count), PW'(16'd0));
      if (k == 16) chk("d_stall_count", PW'(stall_count), PW'(16'd10));
`endif
      if (k <= 5)       drive(4'b1011, {nr3, zp, red0, nr0}, 1'b0);
      else if (k == 6)  drive(4'b1011, {nr3, zp, red0, nr0}, 1'b1);
      else              drive(4'b0010, {zp, zp, red0, zp}, 1'b1);
      eg = (k == 6) ? 4'b1000 : ((k == 16) ? 4'b0010 : 4'b0000);
      eb = (k <= 15) ? 2'b01 : 2'b00;
      step($sformatf("d%0d", k), eg, eb);
    end

    rst = 1'b1;
    drive(4'b0000, {zp, zp, zp, zp}, 1'b1);
    step("r_rst", 4'b0000, 2'b01);
    rst = 1'b0;

    // Ports 0 and 2 hammer slots 0 (local tag) and 1 (remote dst_z).
    for (int k = 0; k <= 17; k++) begin
      drive(4'b0101, {zp, remote1, zp, red0}, 1'b1);
      eg = (k == 0 || k == 16) ? 4'b0001 : ((k == 1 || k == 17) ? 4'b0100 : 4'b0000);
      eb[0] = ((k >= 1) && (k <= 15)) || (k == 17);
      eb[1] = (k >= 2) && (k <= 16);
      step($sformatf("b%0d", k), eg, eb);
    end

    drive(4'b0000, {zp, zp, zp, zp}, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
